// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer_if
//  Purpose  : Groups the store-request handshake, the RAM write port and the
//             buffer status signals of store_buffer into one bundle.
//  Ports    : st_valid/st_ready/st_addr/st_data/st_size  - core store request
//             mem_we/mem_addr/mem_wdata/mem_be/mem_ack   - RAM write port
//             empty/count/misalign                       - buffer status
//  Modports : slave  - the store buffer itself
//             master - the core + RAM side (testbench)
//  Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  st_valid;
   logic                  st_ready;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [DATA_WIDTH-1:0] st_data;
   logic [1:0]            st_size;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_be;
   logic                  mem_ack;
   logic                  empty;
   logic [CNT_W-1:0]      count;
   logic                  misalign;

   modport slave (
      input  st_valid, st_addr, st_data, st_size, mem_ack,
      output st_ready, mem_we, mem_addr, mem_wdata, mem_be, empty, count, misalign
   );

   modport master (
      output st_valid, st_addr, st_data, st_size, mem_ack,
      input  st_ready, mem_we, mem_addr, mem_wdata, mem_be, empty, count, misalign
   );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Buffers CPU store requests in an in-order FIFO and drains them
//             to the data-RAM write port. Byte/half/word stores are converted
//             to a word-aligned address, lane-replicated data and a 4-bit
//             byte enable at enqueue time.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             sb   - store_buffer_if.slave (request, RAM write port, status)
//  Config   : STORE_MISALIGN_TRAP_EN - when defined, misaligned sh/sw stores
//             are accepted but dropped and reported by a 1-cycle misalign
//             pulse; when undefined, misaligned low address bits are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave sb
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // Entry storage; contents are only observed while the entry is valid,
   // so it carries no reset.
   logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
   logic [DATA_WIDTH-1:0] wdata_q [DEPTH];
   logic [3:0]            be_q    [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                  empty;
   logic                  ready;
   logic                  push_fire;
   logic                  enq;
   logic                  pop;
   logic                  size_ok;
   logic [ADDR_WIDTH-1:0] enc_addr;
   logic [DATA_WIDTH-1:0] enc_wdata;
   logic [3:0]            enc_be;

   assign empty     = (count_q == '0);
   assign ready     = (count_q < CNT_W'(DEPTH));
   assign push_fire = sb.st_valid && ready;
   assign pop       = sb.mem_ack && !empty;

   // Request encoding into the RAM write format.
   always_comb begin
      enc_addr  = {sb.st_addr[ADDR_WIDTH-1:2], 2'b00};
      enc_wdata = '0;
      enc_be    = 4'b0000;
      size_ok   = 1'b1;
      case (sb.st_size)
         SIZE_B: begin
            enc_be    = 4'b0001 << sb.st_addr[1:0];
            enc_wdata = {4{sb.st_data[7:0]}};
         end
         SIZE_H: begin
            // Lane pair chosen by addr[1]; addr[0] never moves the lanes.
            enc_be    = 4'b0011 << {sb.st_addr[1], 1'b0};
            enc_wdata = {2{sb.st_data[15:0]}};
         end
         SIZE_W: begin
            enc_be    = 4'b1111;
            enc_wdata = sb.st_data;
         end
         default: size_ok = 1'b0;   // reserved size: handshake only
      endcase
   end

`ifdef STORE_MISALIGN_TRAP_EN
   logic misaligned;
   logic misalign_q, misalign_d;

   assign misaligned = ((sb.st_size == SIZE_H) && sb.st_addr[0]) ||
                       ((sb.st_size == SIZE_W) && (sb.st_addr[1:0] != 2'b00));
   assign enq        = push_fire && size_ok && !misaligned;
   assign misalign_d = push_fire && misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign sb.misalign = misalign_q;
`else
   assign enq         = push_fire && size_ok;
   assign sb.misalign = 1'b0;
`endif

   // Pointer/count next state. Pointers wrap naturally (DEPTH is a power of 2).
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) begin
         tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      case ({enq, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail_q]  <= enc_addr;
         wdata_q[tail_q] <= enc_wdata;
         be_q[tail_q]    <= enc_be;
      end
   end

   // Head outputs are forced to zero while empty, which also gives the
   // all-zero write port after reset.
   assign sb.st_ready  = ready;
   assign sb.mem_we    = !empty;
   assign sb.mem_addr  = empty ? '0 : addr_q[head_q];
   assign sb.mem_wdata = empty ? '0 : wdata_q[head_q];
   assign sb.mem_be    = empty ? 4'b0000 : be_q[head_q];
   assign sb.empty     = empty;
   assign sb.count     = count_q;
endmodule
`default_nettype wire
